// File: rtl/pipelined_array_mult.sv
// Pipelined carry-save array multiplier, unsigned or Baugh-Wooley signed per transaction.
// Sum/carry vectors travel between stages; only the last stage resolves them with a carry-propagate add.
module pipelined_array_mult #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned ROWS_PER_STAGE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 in_signed_i,
    input  logic [WIDTH-1:0]     in_a_i,
    input  logic [WIDTH-1:0]     in_b_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   out_p_o,
    output logic                 out_signed_o
);

    localparam int unsigned LATENCY = WIDTH / ROWS_PER_STAGE;
    localparam int unsigned PW      = 2 * WIDTH;
    localparam int unsigned NREG    = (LATENCY > 1) ? LATENCY - 1 : 1;

    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [PW-1:0]    BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    if (WIDTH < 2 || (WIDTH % ROWS_PER_STAGE) != 0) begin : g_param_check
        $error("pipelined_array_mult: WIDTH must be >= 2 and divisible by ROWS_PER_STAGE");
    end

    // Adds ROWS_PER_STAGE partial-product rows, starting at row 'first', into a sum/carry pair.
    function automatic logic [2*PW-1:0] add_rows(
        input logic [PW-1:0]    s_in,
        input logic [PW-1:0]    c_in,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sg,
        input int unsigned      first
    );
        logic [PW-1:0]    s, c, row, cy;
        logic [WIDTH-1:0] pp, b_sh, inv;
        int unsigned      i;
        s = s_in;
        c = c_in;
        for (int unsigned r = 0; r < ROWS_PER_STAGE; r++) begin
            i    = first + r;
            b_sh = b >> i;
            pp   = a & {WIDTH{b_sh[0]}};
            inv  = (i == WIDTH - 1) ? ~MSB_MASK : MSB_MASK;
            if (sg) begin
                pp = pp ^ inv;
            end
            row = PW'(pp) << i;
            cy  = (s & c) | (s & row) | (c & row);
            s   = s ^ c ^ row;
            c   = cy << 1;
        end
        return {s, c};
    endfunction

    logic stall_c;

    logic [PW-1:0]    s_src  [LATENCY];
    logic [PW-1:0]    c_src  [LATENCY];
    logic [WIDTH-1:0] a_src  [LATENCY];
    logic [WIDTH-1:0] b_src  [LATENCY];
    logic             sg_src [LATENCY];
    logic             v_src  [LATENCY];
    logic [PW-1:0]    s_d    [LATENCY];
    logic [PW-1:0]    c_d    [LATENCY];

    logic [PW-1:0]    s_q  [NREG];
    logic [PW-1:0]    c_q  [NREG];
    logic [WIDTH-1:0] a_q  [NREG];
    logic [WIDTH-1:0] b_q  [NREG];
    logic             sg_q [NREG];
    logic             v_q  [NREG];

    logic [PW-1:0]    out_p_q;
    logic             out_valid_q;
    logic             out_signed_q;

    assign stall_c    = out_valid_q & ~out_ready_i;
    assign in_ready_o = ~stall_c;

    for (genvar k = 0; k < LATENCY; k++) begin : g_stg
        if (k == 0) begin : g_in
            // Stage 0 rows are built straight from the ports; Baugh-Wooley constants seed the sum.
            assign s_src[k]  = in_signed_i ? BW_CONST : '0;
            assign c_src[k]  = '0;
            assign a_src[k]  = in_a_i;
            assign b_src[k]  = in_b_i;
            assign sg_src[k] = in_signed_i;
            assign v_src[k]  = in_valid_i;
        end else begin : g_fwd
            assign s_src[k]  = s_q[k-1];
            assign c_src[k]  = c_q[k-1];
            assign a_src[k]  = a_q[k-1];
            assign b_src[k]  = b_q[k-1];
            assign sg_src[k] = sg_q[k-1];
            assign v_src[k]  = v_q[k-1];
        end

        assign {s_d[k], c_d[k]} = add_rows(s_src[k], c_src[k], a_src[k], b_src[k],
                                           sg_src[k], k * ROWS_PER_STAGE);

        if (k < LATENCY - 1) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s_q[k]  <= '0;
                    c_q[k]  <= '0;
                    a_q[k]  <= '0;
                    b_q[k]  <= '0;
                    sg_q[k] <= 1'b0;
                    v_q[k]  <= 1'b0;
                end else if (!stall_c) begin
                    s_q[k]  <= s_d[k];
                    c_q[k]  <= c_d[k];
                    a_q[k]  <= a_src[k];
                    b_q[k]  <= b_src[k];
                    sg_q[k] <= sg_src[k];
                    v_q[k]  <= v_src[k];
                end
            end
        end
    end

    // Final stage: resolve sum/carry into the registered product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_p_q      <= '0;
            out_signed_q <= 1'b0;
        end else if (!stall_c) begin
            out_valid_q  <= v_src[LATENCY-1];
            out_p_q      <= s_d[LATENCY-1] + c_d[LATENCY-1];
            out_signed_q <= sg_src[LATENCY-1];
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_p_o      = out_p_q;
    assign out_signed_o = out_signed_q;

endmodule

// File: tb/tb_pipelined_array_mult.sv
// Bench for pipelined_array_mult: default 8-bit instance plus a 6-bit / 3-rows-per-stage instance,
// checked every cycle against an arithmetic reference queue, with literal expectations on directed cases.
module tb_pipelined_array_mult;

    localparam int LAT8 = 4;

    logic clk = 1'b0;
    logic rst;

    logic        in_valid8, in_ready8, in_sg8, out_valid8, out_ready8, out_signed8;
    logic [7:0]  in_a8, in_b8;
    logic [15:0] out_p8;

    logic        in_valid6, in_ready6, in_sg6, out_valid6, out_ready6, out_signed6;
    logic [5:0]  in_a6, in_b6;
    logic [11:0] out_p6;

    int total = 0;
    int bad   = 0;

    longint q8p[$];
    bit     q8s[$];
    longint q6p[$];
    bit     q6s[$];

    logic [7:0]  ba [8];
    logic [7:0]  bb [8];
    logic        bs [8];
    logic [15:0] bp [8];

    always #5 clk = ~clk;

    pipelined_array_mult u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid8), .in_ready_o(in_ready8), .in_signed_i(in_sg8),
        .in_a_i(in_a8), .in_b_i(in_b8),
        .out_valid_o(out_valid8), .out_ready_i(out_ready8),
        .out_p_o(out_p8), .out_signed_o(out_signed8)
    );

    pipelined_array_mult #(.WIDTH(6), .ROWS_PER_STAGE(3)) u_dut6 (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid6), .in_ready_o(in_ready6), .in_signed_i(in_sg6),
        .in_a_i(in_a6), .in_b_i(in_b6),
        .out_valid_o(out_valid6), .out_ready_i(out_ready6),
        .out_p_o(out_p6), .out_signed_o(out_signed6)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product: plain integer multiply of the (optionally sign-interpreted) operands.
    function automatic longint mdl(input longint a, input longint b, input bit sg, input int w);
        if (sg) begin
            if (a >= (longint'(1) << (w - 1))) a -= longint'(1) << w;
            if (b >= (longint'(1) << (w - 1))) b -= longint'(1) << w;
        end
        return (a * b) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q8p.delete(); q8s.delete();
        end else begin
            chk("ready8", in_ready8, !(out_valid8 && !out_ready8));
            if (out_valid8) begin
                if (q8p.size() == 0) chk("spurious8", out_valid8, 0);
                else begin
                    chk("p8", out_p8, q8p[0]);
                    chk("sg8", out_signed8, q8s[0]);
                    if (out_ready8) begin
                        void'(q8p.pop_front());
                        void'(q8s.pop_front());
                    end
                end
            end
            if (in_valid8 && in_ready8) begin
                q8p.push_back(mdl(in_a8, in_b8, in_sg8, 8));
                q8s.push_back(in_sg8);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q6p.delete(); q6s.delete();
        end else begin
            chk("ready6", in_ready6, !(out_valid6 && !out_ready6));
            if (out_valid6) begin
                if (q6p.size() == 0) chk("spurious6", out_valid6, 0);
                else begin
                    chk("p6", out_p6, q6p[0]);
                    chk("sg6", out_signed6, q6s[0]);
                    if (out_ready6) begin
                        void'(q6p.pop_front());
                        void'(q6s.pop_front());
                    end
                end
            end
            if (in_valid6 && in_ready6) begin
                q6p.push_back(mdl(in_a6, in_b6, in_sg6, 6));
                q6s.push_back(in_sg6);
            end
        end
    end

    task automatic setv(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] p);
        ba[i] = a; bb[i] = b; bs[i] = s; bp[i] = p;
    endtask

    // Back-to-back accepts with out_ready high; products must appear LAT8 cycles later, contiguously.
    task automatic run_burst(input int n);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    in_a8 = ba[i]; in_b8 = bb[i]; in_sg8 = bs[i]; in_valid8 = 1'b1;
                    @(posedge clk); #1;
                end
                in_valid8 = 1'b0;
            end
            begin
                repeat (LAT8) @(posedge clk);
                #1;
                for (int i = 0; i < n; i++) begin
                    chk("burst_valid", out_valid8, 1);
                    chk("burst_p", out_p8, bp[i]);
                    chk("burst_sg", out_signed8, bs[i]);
                    @(posedge clk); #1;
                end
                chk("burst_drain", out_valid8, 0);
            end
        join
    endtask

    function automatic logic [7:0] pick8();
        case ($urandom_range(7))
            0: return 8'h00;
            1: return 8'h80;
            2: return 8'hFF;
            3: return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic soak8(input int n);
        int sent = 0;
        int w = 0;
        bit acc;
        while (sent < n) begin
            if (!in_valid8 && $urandom_range(3) != 0) begin
                in_a8 = pick8(); in_b8 = pick8(); in_sg8 = 1'($urandom); in_valid8 = 1'b1;
            end
            @(negedge clk); acc = in_valid8 && in_ready8;
            @(posedge clk); #1;
            if (acc) begin sent++; in_valid8 = 1'b0; end
            out_ready8 = ($urandom_range(3) != 0);
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        while ((out_valid8 || q8p.size() != 0) && w < 50) begin @(posedge clk); #1; w++; end
        chk("soak8_drain", out_valid8, 0);
        chk("soak8_left", q8p.size(), 0);
    endtask

    task automatic soak6(input int n);
        int sent = 0;
        int w = 0;
        bit acc;
        while (sent < n) begin
            if (!in_valid6 && $urandom_range(3) != 0) begin
                in_a6 = 6'($urandom); in_b6 = 6'($urandom); in_sg6 = 1'($urandom); in_valid6 = 1'b1;
            end
            @(negedge clk); acc = in_valid6 && in_ready6;
            @(posedge clk); #1;
            if (acc) begin sent++; in_valid6 = 1'b0; end
            out_ready6 = ($urandom_range(3) != 0);
        end
        in_valid6 = 1'b0; out_ready6 = 1'b1;
        while ((out_valid6 || q6p.size() != 0) && w < 50) begin @(posedge clk); #1; w++; end
        chk("soak6_drain", out_valid6, 0);
        chk("soak6_left", q6p.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; in_sg8 = 1'b0; in_a8 = '0; in_b8 = '0; out_ready8 = 1'b1;
        in_valid6 = 1'b0; in_sg6 = 1'b0; in_a6 = '0; in_b6 = '0; out_ready6 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid8", out_valid8, 0);
        chk("rst_p8", out_p8, 0);
        chk("rst_sg8", out_signed8, 0);
        chk("rst_valid6", out_valid6, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready8", in_ready8, 1);
        chk("rst_ready6", in_ready6, 1);
        @(posedge clk); #1;

        // Unsigned extremes
        setv(0, 8'd255, 8'd255, 1'b0, 16'hFE01);
        setv(1, 8'd0,   8'd200, 1'b0, 16'h0000);
        setv(2, 8'd1,   8'd1,   1'b0, 16'h0001);
        run_burst(3);

        // Signed corners
        setv(0, 8'h80, 8'h80, 1'b1, 16'h4000);
        setv(1, 8'hFF, 8'h7F, 1'b1, 16'hFF81);
        setv(2, 8'h80, 8'h7F, 1'b1, 16'hC080);
        setv(3, 8'h7F, 8'h7F, 1'b1, 16'h3F01);
        run_burst(4);

        // Alternating modes on identical operands
        setv(0, 8'hFF, 8'h02, 1'b1, 16'hFFFE);
        setv(1, 8'hFF, 8'h02, 1'b0, 16'h01FE);
        setv(2, 8'hFF, 8'h02, 1'b1, 16'hFFFE);
        setv(3, 8'hFF, 8'h02, 1'b0, 16'h01FE);
        run_burst(4);

        // Backpressure: fill, stall 5 cycles with a pending input, then release
        setv(0, 8'd10,  8'd20,  1'b0, 16'h00C8);
        setv(1, 8'd3,   8'd7,   1'b0, 16'h0015);
        setv(2, 8'd255, 8'd2,   1'b0, 16'h01FE);
        setv(3, 8'd100, 8'd100, 1'b0, 16'h2710);
        for (int i = 0; i < 4; i++) begin
            in_a8 = ba[i]; in_b8 = bb[i]; in_sg8 = bs[i]; in_valid8 = 1'b1;
            @(posedge clk); #1;
        end
        in_a8 = 8'd9; in_b8 = 8'd9; in_sg8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", in_ready8, 0);
            chk("bp_valid", out_valid8, 1);
            chk("bp_hold_p", out_p8, 16'h00C8);
            @(posedge clk); #1;
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready8, 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        chk("bp_next_valid", out_valid8, 1);
        chk("bp_next_p", out_p8, 16'h0015);
        repeat (8) @(posedge clk);
        #1;
        chk("bp_drained", out_valid8, 0);

        // Reset mid-stream while a product is being presented
        for (int i = 0; i < 3; i++) begin
            in_a8 = ba[i]; in_b8 = bb[i]; in_sg8 = 1'b1; in_valid8 = 1'b1;
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid8, 0);
        chk("mid_rst_p", out_p8, 0);
        chk("mid_rst_sg", out_signed8, 0);
        @(posedge clk); #2;
        rst = 1'b0; out_ready8 = 1'b1;
        @(posedge clk); #1;
        setv(0, 8'd3, 8'd5, 1'b0, 16'h000F);
        run_burst(1);

        soak8(2000);
        soak6(10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
